// File: rtl/map_ram_arbiter.sv
// Arbiter sharing port A of the 4-bit map RAM among game-logic requesters.
// One read or write of a single map cell in flight at a time; out-of-map addresses never reach the RAM.
module map_ram_arbiter #(
  parameter int N_REQ      = 4,
  parameter int RD_LATENCY = 1,
  parameter int MAP_CELLS  = 150,
  parameter int FIXED_PRIO = 0
) (
  input  logic                 clk100m,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_we,
  input  logic [8*N_REQ-1:0]   req_addr,
  input  logic [4*N_REQ-1:0]   req_din,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [3:0]           rdata,
  output logic                 vgaram_we,
  output logic [7:0]           vgaram_addra,
  output logic [3:0]           vgaram_dina,
  input  logic [3:0]           vgaram_douta
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] CNT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [8:0] MAP_LIM  = 9'(MAP_CELLS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic              we_reg;
  logic              oor_reg;
  logic [1:0]        cnt_reg;

  logic [7:0]        addr_arr [N_REQ];
  logic [3:0]        din_arr  [N_REQ];
  logic [ID_W-1:0]   cand     [N_REQ];
  logic [ID_W-1:0]   ptr_eff;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   ptr_next;
  logic              win_in_range;

  assign ptr_eff = (FIXED_PRIO != 0) ? '0 : ptr_reg;

  // cand[k] is the requester index examined k-th, starting at the pointer.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[8*gi +: 8];
    assign din_arr[gi]  = req_din[4*gi +: 4];
    assign cand[gi]     = ID_W'((int'(ptr_eff) + gi) % N_REQ);
  end

  // Scanning from the far end means the earliest candidate in order wins.
  always_comb begin
    win_id = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) win_id = cand[k];
    end
  end

  assign ptr_next     = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
  assign win_in_range = ({1'b0, addr_arr[win_id]} < MAP_LIM);

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_ff @(posedge clk100m or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      id_reg       <= '0;
      we_reg       <= 1'b0;
      oor_reg      <= 1'b0;
      cnt_reg      <= '0;
      gnt          <= '0;
      done         <= '0;
      err          <= 1'b0;
      rdata        <= '0;
      vgaram_we    <= 1'b0;
      vgaram_addra <= '0;
      vgaram_dina  <= '0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      vgaram_we <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            id_reg    <= win_id;
            we_reg    <= req_we[win_id];
            gnt       <= onehot(win_id);
            state_reg <= ISSUE;
            if (FIXED_PRIO == 0) ptr_reg <= ptr_next;
            if (win_in_range) begin
              oor_reg      <= 1'b0;
              vgaram_addra <= addr_arr[win_id];
              vgaram_we    <= req_we[win_id];
              vgaram_dina  <= din_arr[win_id];
            end else begin
              oor_reg <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!we_reg && !oor_reg) begin
            cnt_reg   <= '0;
            state_reg <= WAIT;
          end else begin
            done      <= onehot(id_reg);
            err       <= oor_reg;
            state_reg <= RESP;
          end
        end
        WAIT: begin
          // Address stays on vgaram_addra until the data is captured.
          if (cnt_reg == CNT_LAST) begin
            rdata     <= vgaram_douta;
            done      <= onehot(id_reg);
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 2'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Scoreboard bench for map_ram_arbiter: a round-robin and map-memory model predicts grants and
// responses; a monitor checks every gnt/done pulse against the predictions.
module tb_map_ram_arbiter;
  localparam int N     = 4;
  localparam int RD_L  = 1;
  localparam int CELLS = 150;

  logic          clk100m = 1'b0;
  logic          rst_n   = 1'b0;
  logic [N-1:0]  req     = '0;
  logic [N-1:0]  req_we  = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [4*N-1:0] req_din  = '0;
  logic [N-1:0]  gnt, done;
  logic          err;
  logic [3:0]    rdata;
  logic          vgaram_we;
  logic [7:0]    vgaram_addra;
  logic [3:0]    vgaram_dina;
  logic [3:0]    vgaram_douta;

  map_ram_arbiter #(.N_REQ(N), .RD_LATENCY(RD_L), .MAP_CELLS(CELLS), .FIXED_PRIO(0)) dut (
    .clk100m(clk100m), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .vgaram_we(vgaram_we), .vgaram_addra(vgaram_addra), .vgaram_dina(vgaram_dina),
    .vgaram_douta(vgaram_douta)
  );

  always #5 clk100m = ~clk100m;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk100m) cyc <= cyc + 1;

  // RAM port A: registered read, RD_L cycles from address to data.
  logic [3:0] ram [256];
  logic [3:0] dpipe [RD_L];
  always @(posedge clk100m) begin
    if (vgaram_we) ram[vgaram_addra] <= vgaram_dina;
    dpipe[0] <= ram[vgaram_addra];
    for (int i = 1; i < RD_L; i++) dpipe[i] <= dpipe[i-1];
  end
  assign vgaram_douta = dpipe[RD_L-1];

  typedef struct {int id; bit we; bit chk_addr; logic [7:0] addr; logic [3:0] din;} exp_gnt_t;
  typedef struct {int id; bit err; bit chk_rd; logic [3:0] rdata; int lat;} exp_done_t;
  exp_gnt_t  exp_gnt [$];
  exp_done_t exp_q   [$];

  // Reference model state: cell contents, which cells hold known data, round-robin pointer.
  logic [3:0] mem   [256];
  bit         known [256];
  int         mptr = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int rr_pick(logic [N-1:0] act, int p);
    for (int k = 0; k < N; k++) if (act[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Monitor: compares every grant / done pulse against the queued predictions.
  exp_gnt_t  mg;
  exp_done_t md;
  int        gnt_cyc = 0;
  always @(negedge clk100m) begin
    if (rst_n) begin
      if (gnt != '0) begin
        if (exp_gnt.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_gnt: got %b expected none", gnt);
        end else begin
          mg = exp_gnt.pop_front();
          chk("gnt_id", 32'(gnt), 32'(1) << mg.id);
          chk("gnt_vgaram_we", 32'(vgaram_we), 32'(mg.we));
          if (mg.chk_addr) chk("gnt_addra", 32'(vgaram_addra), 32'(mg.addr));
          if (mg.we) chk("gnt_dina", 32'(vgaram_dina), 32'(mg.din));
          $display("[TB] gnt  id=%0d we=%0b addra=%0d dina=%0d", mg.id, vgaram_we, vgaram_addra, vgaram_dina);
        end
        gnt_cyc = cyc;
      end
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got %b expected none", done);
        end else begin
          md = exp_q.pop_front();
          chk("done_id", 32'(done), 32'(1) << md.id);
          chk("done_err", 32'(err), 32'(md.err));
          chk("latency", 32'(cyc - gnt_cyc), 32'(md.lat));
          if (md.chk_rd) chk("rdata", 32'(rdata), 32'(md.rdata));
          $display("[TB] done id=%0d err=%0b rdata=%0d", md.id, err, rdata);
        end
      end else begin
        chk("err_without_done", 32'(err), 32'd0);
      end
      if (vgaram_we) chk("we_in_range", 32'(vgaram_addra < 8'(CELLS)), 32'd1);
    end
  end

  task automatic model_grant(input logic [N-1:0] act, input bit hold, input int ngr,
                             input logic [N-1:0] we, input logic [8*N-1:0] addr,
                             input logic [4*N-1:0] din, input bit want_done);
    exp_gnt_t   eg;
    exp_done_t  ed;
    logic [7:0] ad;
    bit         oor;
    int         w;
    for (int n = 0; n < ngr; n++) begin
      w    = rr_pick(act, mptr);
      mptr = (w + 1) % N;
      if (!hold) act[w] = 1'b0;
      ad  = addr[8*w +: 8];
      oor = (ad >= 8'(CELLS));
      eg.id = w; eg.we = we[w] && !oor; eg.chk_addr = !oor; eg.addr = ad; eg.din = din[4*w +: 4];
      exp_gnt.push_back(eg);
      ed.id = w; ed.err = oor; ed.chk_rd = !we[w] && !oor && known[ad]; ed.rdata = mem[ad];
      ed.lat = (!we[w] && !oor) ? 1 + RD_L : 1;
      if (want_done) exp_q.push_back(ed);
      if (we[w] && !oor && want_done) begin
        mem[ad]   = din[4*w +: 4];
        known[ad] = 1'b1;
      end
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((exp_q.size() != 0 || exp_gnt.size() != 0) && b < 100) begin
      @(negedge clk100m);
      b++;
    end
    if (exp_q.size() != 0 || exp_gnt.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size() + exp_gnt.size());
      exp_q.delete(); exp_gnt.delete();
    end
  endtask

  task automatic run_batch(input logic [N-1:0] set, input bit hold, input int ngr,
                           input logic [N-1:0] we, input logic [8*N-1:0] addr, input logic [4*N-1:0] din);
    int seen   = 0;
    int budget = 200;
    model_grant(set, hold, ngr, we, addr, din, 1'b1);
    @(negedge clk100m);
    req_we = we; req_addr = addr; req_din = din; req = set;
    while (seen < ngr && budget > 0) begin
      @(negedge clk100m);
      budget--;
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          seen++;
          if (!hold) req[i] = 1'b0;
        end
      end
      if (seen >= ngr) req = '0;
    end
    if (seen < ngr) begin
      tests++; fails++;
      $display("FAIL grant_timeout: got %0d grants expected %0d", seen, ngr);
      req = '0;
      exp_q.delete(); exp_gnt.delete();
    end
    wait_drain();
  endtask

  task automatic do_reset();
    @(negedge clk100m);
    rst_n = 1'b0;
    repeat (2) @(negedge clk100m);
    rst_n = 1'b1;
    mptr = 0;
    exp_q.delete(); exp_gnt.delete();
  endtask

  function automatic logic [31:0] rst_outs();
    return 32'({gnt, done, err, rdata, vgaram_we, vgaram_addra, vgaram_dina});
  endfunction

  logic [N-1:0]   r_set, r_we;
  logic [8*N-1:0] r_addr;
  logic [4*N-1:0] r_din;
  int             r_sel;
  bit             r_hold;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 4'd0;
      known[i] = 1'b0;
    end
    repeat (2) @(negedge clk100m);
    chk("reset_outputs", rst_outs(), 32'd0);
    rst_n = 1'b1;

    // Write 9 to cell 37 from requester 2, read it back, overwrite with 15, read again.
    run_batch(4'b0100, 1'b0, 1, 4'b0100, 32'd37 << 16, 16'd9 << 8);
    run_batch(4'b0100, 1'b0, 1, 4'b0000, 32'd37 << 16, 16'd0);
    run_batch(4'b0100, 1'b0, 1, 4'b0100, 32'd37 << 16, 16'd15 << 8);
    run_batch(4'b0100, 1'b0, 1, 4'b0000, 32'd37 << 16, 16'd0);

    // Range boundary: 150 and 255 rejected, 149 written then read.
    run_batch(4'b0111, 1'b0, 3, 4'b0111, {8'd0, 8'd149, 8'd255, 8'd150}, 16'h0655);
    run_batch(4'b1000, 1'b0, 1, 4'b0000, {8'd149, 24'd0}, 16'd0);
    run_batch(4'b0001, 1'b0, 1, 4'b0000, 32'd150, 16'd0);

    // All four held from reset: grants 0,1,2,3,0.
    do_reset();
    run_batch(4'b1111, 1'b1, 5, 4'b1111, {8'd43, 8'd42, 8'd41, 8'd40}, 16'h4321);

    // A one-cycle pulse on req[1] while req[0] is serviced is never granted.
    model_grant(4'b0001, 1'b0, 1, 4'b0000, {24'd0, 8'd40}, 16'd0, 1'b1);
    @(negedge clk100m);
    req_we = '0; req_addr = {24'd0, 8'd40}; req = 4'b0001;
    for (int b = 0; b < 20 && !gnt[0]; b++) @(negedge clk100m);
    req[0] = 1'b0;
    req[1] = 1'b1;
    @(negedge clk100m);
    req[1] = 1'b0;
    wait_drain();
    repeat (6) @(negedge clk100m);

    // Async reset in WAIT of a read abandons it; pointer returns to 0 so req[1] beats req[3].
    model_grant(4'b0100, 1'b0, 1, 4'b0000, 32'd10 << 16, 16'd0, 1'b0);
    @(negedge clk100m);
    req_we = '0; req_addr = 32'd10 << 16; req = 4'b0100;
    for (int b = 0; b < 20 && !gnt[2]; b++) @(negedge clk100m);
    req = '0;
    wait_drain();
    @(posedge clk100m);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", rst_outs(), 32'd0);
    repeat (2) @(negedge clk100m);
    chk("reset_hold_outputs", rst_outs(), 32'd0);
    rst_n = 1'b1;
    mptr  = 0;
    exp_q.delete(); exp_gnt.delete();
    run_batch(4'b1010, 1'b0, 2, 4'b0000, {8'd12, 8'd0, 8'd11, 8'd0}, 16'd0);

    // Randomized batches.
    for (int it = 0; it < 60; it++) begin
      r_set  = 4'($urandom_range(1, 15));
      r_we   = 4'($urandom);
      r_hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        r_sel = $urandom_range(0, 9);
        r_addr[8*i +: 8] = (r_sel < 6) ? 8'($urandom_range(0, 15)) :
                           (r_sel == 6) ? 8'd149 : (r_sel == 7) ? 8'd150 : 8'($urandom_range(0, 255));
        r_din[4*i +: 4]  = 4'($urandom);
      end
      run_batch(r_set, r_hold, $countones(r_set) + (r_hold ? 2 : 0), r_we, r_addr, r_din);
    end

    repeat (5) @(negedge clk100m);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
